// File: rtl/controle_varredura_matriz.sv
// Row-scan sequencer for the 5x7 LED matrix: row index, active-low row drive, blanking and frame select.
// Define QUADRO_AUTO_EN to enable dwell-based automatic frame advance (and pausa); otherwise frames move only on avanca.
module controle_varredura_matriz #(
  parameter int DIV_TICK     = 4,
  parameter int BLANK_CICLOS = 1,
  parameter int NUM_LINHAS   = 7,
  parameter int NUM_QUADROS  = 8,
  parameter int DWELL        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic                  pausa,
  input  logic                  avanca,
  output logic [2:0]            contador,
  output logic [NUM_LINHAS-1:0] linhas,
  output logic [2:0]            quadro,
  output logic                  apagar,
  output logic                  fim_varredura
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } estado_t;

  localparam int MAXT = (DIV_TICK > BLANK_CICLOS) ? DIV_TICK : BLANK_CICLOS;
  localparam int PW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  estado_t               estado_q, estado_d;
  logic [PW-1:0]         tick_q, tick_d;
  logic [2:0]            contador_q, contador_d;
  logic [2:0]            quadro_q, quadro_d;
  logic [NUM_LINHAS-1:0] linhas_q, linhas_d;
  logic                  apagar_q, apagar_d;
  logic                  fim_q, fim_d;
  logic                  pend_q, pend_d;
  logic                  wrap;
  logic                  troca;
  logic                  avanca_ef;
  logic                  dwell_ok;
  logic [2:0]            quadro_prox;

`ifdef QUADRO_AUTO_EN
  localparam int SW = $clog2(DWELL + 1);
  logic [SW-1:0] scan_q, scan_d;
`else
  logic unused_cfg;
  assign unused_cfg = pausa & (DWELL > 0);
`endif

  // State register: every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= IDLE;
      tick_q     <= '0;
      contador_q <= 3'd0;
      quadro_q   <= 3'd0;
      linhas_q   <= '1;
      apagar_q   <= 1'b1;
      fim_q      <= 1'b0;
      pend_q     <= 1'b0;
`ifdef QUADRO_AUTO_EN
      scan_q     <= '0;
`endif
    end else begin
      estado_q   <= estado_d;
      tick_q     <= tick_d;
      contador_q <= contador_d;
      quadro_q   <= quadro_d;
      linhas_q   <= linhas_d;
      apagar_q   <= apagar_d;
      fim_q      <= fim_d;
      pend_q     <= pend_d;
`ifdef QUADRO_AUTO_EN
      scan_q     <= scan_d;
`endif
    end
  end

  // Next state: slot timing and row stepping; wrap marks contador returning to 0.
  always_comb begin
    estado_d   = estado_q;
    tick_d     = tick_q + 1'b1;
    contador_d = contador_q;
    wrap       = 1'b0;
    if (!habilita) begin
      estado_d   = IDLE;
      tick_d     = '0;
      contador_d = 3'd0;
    end else begin
      case (estado_q)
        IDLE: begin
          estado_d   = SHOW;
          tick_d     = '0;
          contador_d = 3'd0;
        end
        SHOW: begin
          if (tick_q == PW'(DIV_TICK - 1)) begin
            tick_d = '0;
            if (BLANK_CICLOS == 0) begin
              if (int'(contador_q) == NUM_LINHAS - 1) begin
                contador_d = 3'd0;
                wrap       = 1'b1;
              end else begin
                contador_d = contador_q + 3'd1;
              end
            end else begin
              estado_d = BLANK;
            end
          end
        end
        BLANK: begin
          if (tick_q == PW'(BLANK_CICLOS - 1)) begin
            estado_d = SHOW;
            tick_d   = '0;
            if (int'(contador_q) == NUM_LINHAS - 1) begin
              contador_d = 3'd0;
              wrap       = 1'b1;
            end else begin
              contador_d = contador_q + 3'd1;
            end
          end
        end
        default: begin
          estado_d   = IDLE;
          tick_d     = '0;
          contador_d = 3'd0;
        end
      endcase
    end
  end

  // Frame selection only changes on a row wrap, so a frame is never torn mid-scan.
  always_comb begin
    avanca_ef   = pend_q | avanca;
    dwell_ok    = 1'b0;
    quadro_prox = (int'(quadro_q) == NUM_QUADROS - 1) ? 3'd0 : quadro_q + 3'd1;
`ifdef QUADRO_AUTO_EN
    dwell_ok    = (int'(scan_q) + 1 >= DWELL) && !pausa;
`endif
    troca    = wrap && (avanca_ef || dwell_ok);
    quadro_d = troca ? quadro_prox : quadro_q;
    pend_d   = 1'b0;
    if (habilita && estado_q != IDLE) begin
      pend_d = avanca_ef && !troca;
    end
`ifdef QUADRO_AUTO_EN
    scan_d = scan_q;
    if (!habilita || troca) begin
      scan_d = '0;
    end else if (wrap) begin
      scan_d = (int'(scan_q) + 1 >= DWELL) ? SW'(DWELL) : scan_q + 1'b1;
    end
`endif
  end

  // Outputs decoded from the next state so they land in flops aligned with it.
  always_comb begin
    linhas_d = '1;
    apagar_d = 1'b1;
    fim_d    = wrap;
    if (estado_d == SHOW) begin
      linhas_d = ~(NUM_LINHAS'(1) << contador_d);
      apagar_d = 1'b0;
    end
  end

  assign contador      = contador_q;
  assign linhas        = linhas_q;
  assign quadro        = quadro_q;
  assign apagar        = apagar_q;
  assign fim_varredura = fim_q;

endmodule
